// File: rtl/wav_pkg.sv
// ---------------------------------------------------------------------------
// wav_pkg
// Shared definitions for the audio capture path:
//   wav_state_e  - recorder FSM states (IDLE, ARMED, RECORD, DONE)
//   MIDSCALE     - 8-bit unsigned midscale value (silence)
//   quantise()   - 16-bit unsigned audio -> 8-bit sample, saturating; the
//                  exact inverse of the player's {1'b0, s, 7'b0} scaling
//   midscale_dev() - absolute distance of an 8-bit sample from MIDSCALE
// ---------------------------------------------------------------------------
package wav_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_RECORD = 2'd2,
        ST_DONE   = 2'd3
    } wav_state_e;

    localparam logic [7:0] MIDSCALE = 8'h80;

    // Any input with bit 15 set exceeds what the player can reproduce from
    // an 8-bit sample, so it clips to full scale.
    function automatic logic [7:0] quantise(input logic [15:0] s);
        return s[15] ? 8'hFF : s[14:7];
    endfunction

    function automatic logic [7:0] midscale_dev(input logic [7:0] q);
        return (q >= MIDSCALE) ? (q - MIDSCALE) : (MIDSCALE - q);
    endfunction

endpackage

// File: rtl/wav_rate_tick.sv
// ---------------------------------------------------------------------------
// wav_rate_tick
// Sample-rate prescaler. Counts 0..PRESCALE-1 while enabled and raises tick
// for the single cycle in which the count equals PRESCALE-1 (the counter
// returns to 0 on the following edge).
// Ports:
//   clk      system clock (clk_sys)
//   reset_n  asynchronous active-low reset, clears the count
//   clr      synchronous clear, has priority over en
//   en       count enable
//   tick     one-cycle pulse at the last count of each period
// ---------------------------------------------------------------------------
module wav_rate_tick #(
    parameter int PRESCALE = 2178
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wav_recorder.sv
// ---------------------------------------------------------------------------
// wav_recorder
// Decimates a free-running unsigned 16-bit audio stream to 8-bit samples at
// one sample per PRESCALE clocks and writes them sequentially into the write
// port of the shared sample RAM, starting at address 0.
//
// Optional feature (macro WAV_RECORDER_TRIGGER_EN): start arms the recorder;
// capture begins on the first sample whose distance from midscale reaches
// THRESH. Without the macro, start begins capture immediately.
//
// Ports:
//   clk       system clock (clk_sys)
//   reset_n   asynchronous active-low reset
//   start     one-cycle pulse, begin capture (ignored while busy)
//   stop      one-cycle pulse, end capture early (ignored in IDLE)
//   audio_in  unsigned audio sample, continuously valid
//   ram_a     RAM write address (holds between writes)
//   ram_d     RAM write data (holds between writes)
//   ram_we    RAM write enable, one-cycle pulse per sample
//   busy      high while ARMED or RECORD
//   done      one-cycle pulse when a capture ends (not on reset)
//   length    samples written by the last/current capture
//   state_dbg current FSM state, for observation only
//
// Handshake: there is no backpressure. Each ram_we cycle is a complete
// write of ram_d to ram_a; the RAM is assumed always ready.
// ---------------------------------------------------------------------------
module wav_recorder
    import wav_pkg::*;
#(
    parameter int         PRESCALE = 2178,
    parameter int         ADDR_W   = 14,
    parameter logic [7:0] THRESH   = 8'd16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [15:0]       audio_in,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_d,
    output logic              ram_we,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   length,
    output wav_state_e        state_dbg
);

    wav_state_e        state;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        q;
    logic              tick;
    logic              rate_clr;
    logic              rate_en;
    logic              last_addr;

    assign q         = quantise(audio_in);
    assign state_dbg = state;
    assign last_addr = (addr == {ADDR_W{1'b1}});

    // Prescaler runs only while recording and sits at 0 otherwise, so the
    // first write lands exactly PRESCALE cycles after RECORD is entered.
    assign rate_en  = (state == ST_RECORD);
    assign rate_clr = (state != ST_RECORD);

`ifdef WAV_RECORDER_TRIGGER_EN
    logic trig_hit;
    logic unused_bits;
    assign trig_hit    = (midscale_dev(q) >= THRESH);
    assign unused_bits = ^audio_in[6:0];
`else
    logic unused_bits;
    assign unused_bits = ^{THRESH, audio_in[6:0]};
`endif

    wav_rate_tick #(
        .PRESCALE (PRESCALE)
    ) u_rate_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (rate_clr),
        .en      (rate_en),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            addr   <= '0;
            ram_a  <= '0;
            ram_d  <= '0;
            ram_we <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            length <= '0;
        end else begin
            ram_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr   <= '0;
                        length <= '0;
                        busy   <= 1'b1;
`ifdef WAV_RECORDER_TRIGGER_EN
                        state  <= ST_ARMED;
`else
                        state  <= ST_RECORD;
`endif
                    end
                end

                ST_ARMED: begin
`ifdef WAV_RECORDER_TRIGGER_EN
                    if (stop) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (trig_hit) begin
                        state <= ST_RECORD;
                    end
`else
                    state <= ST_IDLE;
`endif
                end

                ST_RECORD: begin
                    if (tick) begin
                        ram_we <= 1'b1;
                        ram_a  <= addr;
                        ram_d  <= q;
                        addr   <= addr + 1'b1;
                        length <= length + 1'b1;
                    end
                    // A write on the same tick as stop, or the write that
                    // fills the RAM, still completes before the capture ends.
                    if (stop || (tick && last_addr)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wav_recorder.sv
// ---------------------------------------------------------------------------
// tb_wav_recorder
// Scoreboard bench for wav_recorder with PRESCALE=4, ADDR_W=4. Stimulus
// pushes expected writes {cycle, address, data} and expected done pulses
// {cycle, length}; a monitor pops and compares whenever the DUT pulses
// ram_we or done.
// ---------------------------------------------------------------------------
module tb_wav_recorder;
    import wav_pkg::*;

    localparam int P  = 4;
    localparam int AW = 4;
`ifdef WAV_RECORDER_TRIGGER_EN
    localparam int ARM_LAT = 1;
    localparam logic [15:0] FULL_AUD = 16'h8000;
    localparam logic [7:0]  FULL_Q   = 8'hFF;
`else
    localparam int ARM_LAT = 0;
    localparam logic [15:0] FULL_AUD = 16'h4000;
    localparam logic [7:0]  FULL_Q   = 8'h80;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [15:0]   audio_in = 16'h0000;
    logic [AW-1:0] ram_a;
    logic [7:0]    ram_d;
    logic          ram_we;
    logic          busy;
    logic          done;
    logic [AW:0]   length;
    wav_state_e    state_dbg;

    wav_recorder #(
        .PRESCALE (P),
        .ADDR_W   (AW),
        .THRESH   (8'd16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
        .audio_in  (audio_in),
        .ram_a     (ram_a),
        .ram_d     (ram_d),
        .ram_we    (ram_we),
        .busy      (busy),
        .done      (done),
        .length    (length),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    localparam int WW = 32 + AW + 8;
    localparam int DW = 32 + AW + 1;
    logic [WW-1:0] exp_q[$];
    logic [DW-1:0] done_q[$];

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: outputs change on posedge, sampled on negedge.
    initial begin
        logic [WW-1:0] e;
        logic [DW-1:0] d;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (ram_we) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: got a=%0h d=%0h at cycle %0d expected no write",
                                 ram_a, ram_d, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write{cyc,a,d}", 64'({cyc, ram_a, ram_d}), 64'(e));
                    end
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                    end else begin
                        d = done_q.pop_front();
                        chk("done{cyc,len}", 64'({cyc, length}), 64'(d));
                    end
                    chk("busy_at_done", 64'(busy), 64'(0));
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Runs one capture. n_writes writes are expected; if do_stop, stop is
    // asserted in the cycle of the last write tick, otherwise the capture
    // must end by filling the RAM. extra_start re-pulses start mid-capture.
    task automatic capture(input logic [15:0] aud, input logic [7:0] qexp,
                           input int n_writes, input bit do_stop, input bit extra_start);
        int n0;
        int base;
        int end_cyc;
        audio_in = aud;
        n0 = cyc + 1;
        base = n0 + ARM_LAT;
        start = 1'b1;
        for (int k = 0; k < n_writes; k++)
            exp_q.push_back({32'(base + P * (k + 1)), AW'(k), qexp});
        done_q.push_back({32'(base + P * n_writes), (AW + 1)'(n_writes)});
        end_cyc = base + P * n_writes + 2;
        @(negedge clk);
        while (cyc < end_cyc) begin
            start = extra_start && (cyc == n0 + 5);
            stop  = do_stop && (cyc == base + P * n_writes - 1);
            if (cyc == n0 + 2) begin
                chk("busy_in_record", 64'(busy), 64'(1));
                chk("state_record", 64'(state_dbg), 64'(ST_RECORD));
            end
            @(negedge clk);
        end
        start = 1'b0;
        stop = 1'b0;
        chk("idle_after", 64'(state_dbg), 64'(ST_IDLE));
        chk("busy_after", 64'(busy), 64'(0));
        chk("len_hold", 64'(length), 64'(n_writes));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n0;
        repeat (3) @(negedge clk);
        chk("rst_ram_a", 64'(ram_a), 64'(0));
        chk("rst_ram_d", 64'(ram_d), 64'(0));
        chk("rst_ram_we", 64'(ram_we), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_length", 64'(length), 64'(0));
        chk("rst_state", 64'(state_dbg), 64'(ST_IDLE));
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full-RAM capture with a repeated start mid-capture.
        capture(FULL_AUD, FULL_Q, 16, 1'b0, 1'b1);
        chk("ram_a_hold", 64'(ram_a), 64'(15));

        // stop in IDLE is ignored.
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        chk("idle_stop_state", 64'(state_dbg), 64'(ST_IDLE));
        chk("idle_stop_len", 64'(length), 64'(16));
        chk("idle_stop_busy", 64'(busy), 64'(0));

        // Quantisation patterns, stop on the last write tick.
        capture(16'h8000, 8'hFF, 2, 1'b1, 1'b0);
        capture(16'hFFFF, 8'hFF, 1, 1'b1, 1'b0);
        capture(16'h0080, 8'h01, 3, 1'b1, 1'b0);

        // Reset mid-capture after 5 writes.
        audio_in = 16'h8000;
        n0 = cyc + 1;
        start = 1'b1;
        for (int k = 0; k < 5; k++)
            exp_q.push_back({32'(n0 + ARM_LAT + P * (k + 1)), AW'(k), 8'hFF});
        @(negedge clk);
        start = 1'b0;
        while (cyc < n0 + ARM_LAT + 22) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_ram_a", 64'(ram_a), 64'(0));
        chk("arst_ram_d", 64'(ram_d), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_length", 64'(length), 64'(0));
        chk("arst_state", 64'(state_dbg), 64'(ST_IDLE));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        capture(16'h8000, 8'hFF, 2, 1'b1, 1'b0);

`ifdef WAV_RECORDER_TRIGGER_EN
        // Armed with a midscale input: no writes until the deviation hits THRESH.
        audio_in = 16'h4000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("armed_state", 64'(state_dbg), 64'(ST_ARMED));
        chk("armed_busy", 64'(busy), 64'(1));
        audio_in = 16'h4A00;
        n0 = cyc + 1;
        exp_q.push_back({32'(n0 + P), AW'(0), 8'h94});
        done_q.push_back({32'(n0 + P), (AW + 1)'(1)});
        while (cyc < n0 + P - 1) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (3) @(negedge clk);

        // stop while armed ends the capture with nothing written.
        audio_in = 16'h4000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        done_q.push_back({32'(cyc + 1), (AW + 1)'(0)});
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (3) @(negedge clk);
        chk("armed_stop_len", 64'(length), 64'(0));
`endif

        repeat (4) @(negedge clk);
        chk("writes_left", 64'(exp_q.size()), 64'(0));
        chk("dones_left", 64'(done_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
